// File: rtl/ticket_vend_fsm.sv
// Transaction controller for the train-ticket vending machine: credit tracking,
// one-cycle dispense and change handshake. Optional COLLECT auto-cancel via TICKET_TIMEOUT_EN.
module ticket_vend_fsm #(
  parameter int PRICE_A     = 5,
  parameter int PRICE_B     = 12,
  parameter int CREDIT_W    = 8,
  parameter int CREDIT_MAX  = 99,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin1_en,
  input  logic                coin5_en,
  input  logic                coin10_en,
  input  logic                sel_a_en,
  input  logic                sel_b_en,
  input  logic                cancel_en,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] price,
  output logic                ticket,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0]   COIN1_V  = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W:0]   COIN5_V  = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0]   COIN10_V = (CREDIT_W+1)'(10);
  localparam logic [CREDIT_W:0]   MAX_V    = (CREDIT_W+1)'(CREDIT_MAX);
  localparam logic [CREDIT_W-1:0] PRICE_AV = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_BV = CREDIT_W'(PRICE_B);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [CREDIT_W-1:0] price_reg, price_next;
  logic [CREDIT_W-1:0] change_reg, change_next;
  logic                reject_reg, reject_next;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W:0]   credit_sum;
  logic                any_coin;
  logic                coin_accept;
  logic                timeout_hit;

  assign coin_sum   = (coin1_en  ? COIN1_V  : '0)
                    + (coin5_en  ? COIN5_V  : '0)
                    + (coin10_en ? COIN10_V : '0);
  assign credit_sum = {1'b0, credit_reg} + coin_sum;
  assign any_coin   = coin1_en | coin5_en | coin10_en;

`ifdef TICKET_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_reg;

  // Held at zero outside COLLECT, so every entry into COLLECT starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tmo_cnt_reg <= '0;
    else if (state_reg != S_COLLECT) tmo_cnt_reg <= '0;
    else if (coin_accept)          tmo_cnt_reg <= '0;
    else                           tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end

  assign timeout_hit = (state_reg == S_COLLECT) && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = coin_accept ^ (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    price_next  = price_reg;
    change_next = change_reg;
    reject_next = any_coin;
    coin_accept = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (sel_a_en) begin
          price_next = PRICE_AV;
          state_next = S_COLLECT;
        end else if (sel_b_en) begin
          price_next = PRICE_BV;
          state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel_en || timeout_hit) begin
          // Abort: refund whatever was inserted; coins of this cycle stay rejected.
          if (credit_reg != '0) begin
            change_next = credit_reg;
            credit_next = '0;
            state_next  = S_CHANGE;
          end else begin
            price_next = '0;
            state_next = S_IDLE;
          end
        end else if (credit_sum <= MAX_V) begin
          reject_next = 1'b0;
          coin_accept = any_coin;
          credit_next = credit_sum[CREDIT_W-1:0];
          if (credit_sum >= {1'b0, price_reg})
            state_next = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        change_next = credit_reg - price_reg;
        credit_next = '0;
        if (credit_reg != price_reg) begin
          state_next = S_CHANGE;
        end else begin
          price_next = '0;
          state_next = S_IDLE;
        end
      end
      S_CHANGE: begin
        if (change_ack) begin
          change_next = '0;
          price_next  = '0;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      credit_reg <= '0;
      price_reg  <= '0;
      change_reg <= '0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      price_reg  <= price_next;
      change_reg <= change_next;
      reject_reg <= reject_next;
    end
  end

  assign credit       = credit_reg;
  assign price        = price_reg;
  assign change_amt   = change_reg;
  assign coin_reject  = reject_reg;
  assign ticket       = (state_reg == S_DISPENSE);
  assign change_valid = (state_reg == S_CHANGE);
  assign state        = state_reg;

endmodule

// File: tb/tb_ticket_vend_fsm.sv
// Directed bench for ticket_vend_fsm: vector table plus hand sequences for reset,
// credit ceiling (second instance with PRICE_B=120) and COLLECT timeout.
module tb_ticket_vend_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coin1_en = 0, coin5_en = 0, coin10_en = 0;
  logic sel_a_en = 0, sel_b_en = 0, cancel_en = 0, change_ack = 0;

  logic [7:0] credit, price, change_amt;
  logic       ticket, coin_reject, change_valid;
  logic [1:0] state;

  logic [7:0] b_credit, b_price, b_change_amt;
  logic       b_ticket, b_coin_reject, b_change_valid;
  logic [1:0] b_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ticket_vend_fsm #(.PRICE_A(5), .PRICE_B(12), .CREDIT_W(8), .CREDIT_MAX(99), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin1_en(coin1_en), .coin5_en(coin5_en), .coin10_en(coin10_en),
    .sel_a_en(sel_a_en), .sel_b_en(sel_b_en), .cancel_en(cancel_en), .change_ack(change_ack),
    .credit(credit), .price(price), .ticket(ticket), .coin_reject(coin_reject),
    .change_valid(change_valid), .change_amt(change_amt), .state(state)
  );

  ticket_vend_fsm #(.PRICE_A(5), .PRICE_B(120), .CREDIT_W(8), .CREDIT_MAX(99), .TIMEOUT_CYC(1000000)) dut_big (
    .clk(clk), .rst_n(rst_n),
    .coin1_en(coin1_en), .coin5_en(coin5_en), .coin10_en(coin10_en),
    .sel_a_en(sel_a_en), .sel_b_en(sel_b_en), .cancel_en(cancel_en), .change_ack(change_ack),
    .credit(b_credit), .price(b_price), .ticket(b_ticket), .coin_reject(b_coin_reject),
    .change_valid(b_change_valid), .change_amt(b_change_amt), .state(b_state)
  );

  // Input bits: {coin1, coin5, coin10, sel_a, sel_b, cancel, ack}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_C1   = 7'b1000000;
  localparam logic [6:0] I_C5   = 7'b0100000;
  localparam logic [6:0] I_C10  = 7'b0010000;
  localparam logic [6:0] I_SA   = 7'b0001000;
  localparam logic [6:0] I_SB   = 7'b0000100;
  localparam logic [6:0] I_CAN  = 7'b0000010;
  localparam logic [6:0] I_ACK  = 7'b0000001;

  typedef struct {
    logic [6:0] in;
    logic [1:0] st;
    logic [7:0] cr;
    logic [7:0] pr;
    logic       tk;
    logic       rj;
    logic       cv;
    logic [7:0] amt;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs[NV];

  task automatic cyc(input logic [6:0] v);
    @(negedge clk);
    {coin1_en, coin5_en, coin10_en, sel_a_en, sel_b_en, cancel_en, change_ack} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("ok   %s value=%0h", name, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    {coin1_en, coin5_en, coin10_en, sel_a_en, sel_b_en, cancel_en, change_ack} = I_NONE;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [28:0] got_v, exp_v;

    //          inputs          st     credit  price  tk rj cv amt
    vecs[0]  = '{I_SA,          2'd1,  8'd0,   8'd5,  0, 0, 0, 8'd0};
    vecs[1]  = '{I_C5,          2'd2,  8'd5,   8'd5,  1, 0, 0, 8'd0};
    vecs[2]  = '{I_NONE,        2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};
    vecs[3]  = '{I_SB,          2'd1,  8'd0,   8'd12, 0, 0, 0, 8'd0};
    vecs[4]  = '{I_C10,         2'd1,  8'd10,  8'd12, 0, 0, 0, 8'd0};
    vecs[5]  = '{I_C5,          2'd2,  8'd15,  8'd12, 1, 0, 0, 8'd0};
    vecs[6]  = '{I_NONE,        2'd3,  8'd0,   8'd12, 0, 0, 1, 8'd3};
    vecs[7]  = '{I_NONE,        2'd3,  8'd0,   8'd12, 0, 0, 1, 8'd3};
    vecs[8]  = '{I_NONE,        2'd3,  8'd0,   8'd12, 0, 0, 1, 8'd3};
    vecs[9]  = '{I_NONE,        2'd3,  8'd0,   8'd12, 0, 0, 1, 8'd3};
    vecs[10] = '{I_ACK,         2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};
    vecs[11] = '{I_C1,          2'd0,  8'd0,   8'd0,  0, 1, 0, 8'd0};
    vecs[12] = '{I_C10 | I_C5,  2'd0,  8'd0,   8'd0,  0, 1, 0, 8'd0};
    vecs[13] = '{I_CAN,         2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};
    vecs[14] = '{I_SB,          2'd1,  8'd0,   8'd12, 0, 0, 0, 8'd0};
    vecs[15] = '{I_C10,         2'd1,  8'd10,  8'd12, 0, 0, 0, 8'd0};
    vecs[16] = '{I_CAN | I_C1,  2'd3,  8'd0,   8'd12, 0, 1, 1, 8'd10};
    vecs[17] = '{I_ACK,         2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};
    vecs[18] = '{I_SA | I_SB,   2'd1,  8'd0,   8'd5,  0, 0, 0, 8'd0};
    vecs[19] = '{I_SB | I_C1,   2'd1,  8'd1,   8'd5,  0, 0, 0, 8'd0};
    vecs[20] = '{I_CAN,         2'd3,  8'd0,   8'd5,  0, 0, 1, 8'd1};
    vecs[21] = '{I_ACK,         2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};
    vecs[22] = '{I_SA,          2'd1,  8'd0,   8'd5,  0, 0, 0, 8'd0};
    vecs[23] = '{I_CAN,         2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};
    vecs[24] = '{I_SA,          2'd1,  8'd0,   8'd5,  0, 0, 0, 8'd0};
    vecs[25] = '{I_C10,         2'd2,  8'd10,  8'd5,  1, 0, 0, 8'd0};
    vecs[26] = '{I_C1,          2'd3,  8'd0,   8'd5,  0, 1, 1, 8'd5};
    vecs[27] = '{I_C1 | I_ACK,  2'd0,  8'd0,   8'd0,  0, 1, 0, 8'd0};
    vecs[28] = '{I_ACK,         2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};
    vecs[29] = '{I_SB,          2'd1,  8'd0,   8'd12, 0, 0, 0, 8'd0};
    vecs[30] = '{I_C1 | I_C5 | I_C10, 2'd2, 8'd16, 8'd12, 1, 0, 0, 8'd0};
    vecs[31] = '{I_NONE,        2'd3,  8'd0,   8'd12, 0, 0, 1, 8'd4};
    vecs[32] = '{I_ACK,         2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};
    vecs[33] = '{I_NONE,        2'd0,  8'd0,   8'd0,  0, 0, 0, 8'd0};

    do_reset();
    #1;
    chk("reset_outputs", {3'b0, state, credit, price, ticket, coin_reject, change_valid, change_amt}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].in);
      got_v = {state, credit, price, ticket, coin_reject, change_valid, change_amt};
      exp_v = {vecs[i].st, vecs[i].cr, vecs[i].pr, vecs[i].tk, vecs[i].rj, vecs[i].cv, vecs[i].amt};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL vec%0d in=%b got st=%0d cr=%0d pr=%0d tk=%b rj=%b cv=%b amt=%0d expected st=%0d cr=%0d pr=%0d tk=%b rj=%b cv=%b amt=%0d",
                 i, vecs[i].in, state, credit, price, ticket, coin_reject, change_valid, change_amt,
                 vecs[i].st, vecs[i].cr, vecs[i].pr, vecs[i].tk, vecs[i].rj, vecs[i].cv, vecs[i].amt);
      end else begin
        $display("ok   vec%0d in=%b st=%0d cr=%0d pr=%0d tk=%b rj=%b cv=%b amt=%0d",
                 i, vecs[i].in, state, credit, price, ticket, coin_reject, change_valid, change_amt);
      end
    end

    // Asynchronous reset in the middle of COLLECT with credit 7.
    cyc(I_SB);
    cyc(I_C5);
    cyc(I_C1);
    cyc(I_C1);
    cyc(I_NONE);
    chk("pre_reset_credit", {24'd0, credit}, 32'd7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {3'b0, state, credit, price, ticket, coin_reject, change_valid, change_amt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Credit ceiling on the PRICE_B=120 instance.
    do_reset();
    cyc(I_SB);
    for (int i = 0; i < 9; i++) cyc(I_C10);
    cyc(I_C5);
    chk("big_credit_95", {24'd0, b_credit}, 32'd95);
    cyc(I_C10);
    chk("big_over_max_credit", {24'd0, b_credit}, 32'd95);
    chk("big_over_max_reject", {31'd0, b_coin_reject}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(I_C1);
    chk("big_at_max_credit", {24'd0, b_credit}, 32'd99);
    chk("big_at_max_noreject", {31'd0, b_coin_reject}, 32'd0);
    cyc(I_C1);
    chk("big_max_plus1_credit", {24'd0, b_credit}, 32'd99);
    chk("big_max_plus1_reject", {31'd0, b_coin_reject}, 32'd1);
    cyc(I_CAN);
    chk("big_cancel_change", {23'd0, b_change_valid, b_change_amt}, {23'd0, 1'b1, 8'd99});

    // COLLECT timeout on the TIMEOUT_CYC=20 instance.
    do_reset();
    cyc(I_SA);
    cyc(I_C1);
    chk("tmo_credit_1", {24'd0, credit}, 32'd1);
    n = 0;
    while (!change_valid && n < 40) begin
      cyc(I_NONE);
      n++;
    end
`ifdef TICKET_TIMEOUT_EN
    chk("tmo_cycles", n, 32'd20);
    chk("tmo_change", {23'd0, change_valid, change_amt}, {23'd0, 1'b1, 8'd1});
`else
    chk("no_tmo_state", {30'd0, state}, 32'd1);
    chk("no_tmo_credit", {23'd0, change_valid, credit}, {23'd0, 1'b0, 8'd1});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
